led_seq_ctrl: RTL
=================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 4, number of LEDs driven (min 2).
REQ-002 SHALL have parameter TICK_BASE, default 12_500_000, clock cycles per step at fastest speed (0.25 s at 50 MHz).
REQ-003 SHALL have parameter DEB_CNT, default 1_000_000, clock cycles a key must stay stable to be accepted (20 ms at 50 MHz).
REQ-004 SHALL have port sys_clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port key_mode, input, 1, raw active-low push-button that advances the mode.
REQ-007 SHALL have port key_speed, input, 1, raw active-low push-button that advances the speed.
REQ-008 SHALL have port led, output, LED_W, registered LED drive, 1 = on.
REQ-009 SHALL have port mode, output, 2, current mode index.
REQ-010 SHALL have port spd, output, 2, current speed index.

Function
REQ-011 Each key SHALL pass through a 2-FF synchronizer, then a debouncer whose counter resets on any change of the synchronized level and updates the debounced level after DEB_CNT consecutive stable cycles.
REQ-012 A one-cycle press pulse SHALL be asserted on the high-to-low transition of the debounced level only; release SHALL produce no pulse; a held key SHALL produce exactly one pulse.
REQ-013 Press-pulse latency SHALL be DEB_CNT+3 cycles or fewer from a clean key falling edge; glitches shorter than DEB_CNT cycles SHALL produce no pulse.
REQ-014 Step period SHALL be TICK_BASE << spd cycles (spd 0/1/2 = 1x/2x/4x); the tick counter SHALL count 0 to period-1, assert tick for one cycle at period-1, then wrap to 0.
REQ-015 Tick counter width SHALL hold 4*TICK_BASE-1 without overflow (26 bits at default).
REQ-016 Modes SHALL be: 0 FLOW_L, 1 FLOW_R, 2 BLINK, 3 HOLD.
REQ-017 FLOW_L: on tick, led rotates left ({led[LED_W-2:0], led[LED_W-1]}); initial pattern one-hot bit 0.
REQ-018 FLOW_R: on tick, led rotates right; initial pattern one-hot bit LED_W-1.
REQ-019 BLINK: on tick, led inverts; initial pattern all ones.
REQ-020 HOLD: led frozen at its value on entry; tick counter held at 0.
REQ-021 Mode press SHALL set mode to mode+1, wrapping 3 to 0; in the following cycle led SHALL hold the new mode's initial pattern (unchanged for HOLD) and the tick counter SHALL be 0.
REQ-022 Speed press SHALL set spd to spd+1, wrapping 2 to 0, and clear the tick counter; led SHALL be unchanged.
REQ-023 Mode and speed presses in the same cycle SHALL both take effect in that cycle.
REQ-024 A press in the same cycle as a tick SHALL take priority; no led step occurs that cycle.
REQ-025 Encoding spd=3 SHALL be unreachable; if present it SHALL be treated as spd 0.

Reset
REQ-026 On sys_rst_n low, asynchronously: mode=0 (FLOW_L), spd=1, led=one-hot bit 0, tick counter=0, debounce counters=0, synchronizer and debounced levels=1 (released).
REQ-027 Reset asserted mid-step or mid-debounce SHALL discard all progress; no press pulse SHALL be generated by reset release while a key is held low until DEB_CNT stable cycles have elapsed.

Structure
REQ-028 Mode encodings (FLOW_L, FLOW_R, BLINK, HOLD), speed count (3) and reset values SHALL reside in shared package led_pkg.
REQ-029 Debounce plus press-pulse logic SHALL be one sub-module, key_debounce (parameter DEB_CNT), instantiated once per key.
REQ-030 Tick generator and mode/led FSM SHALL reside in led_seq_ctrl; no other sub-modules.

Verification (LED_W=4, TICK_BASE=4, DEB_CNT=3)
REQ-031 Reset release, no keys -> led 0001, then 0010 after 8 cycles, then 0100 after 16, wrapping to 0001 after 32.
REQ-032 key_mode low for 10 cycles -> exactly one press; mode=1, led=1000, then 0100 after 8 cycles; 2-cycle glitch -> no change.
REQ-033 Three further mode presses -> BLINK shows 1111/0000 alternating every 8 cycles; HOLD freezes led with no change over 100 cycles; next press -> FLOW_L, led 0001.
REQ-034 key_speed presses from spd=1 -> spd 2 (period 16), then 0 (period 4); tick counter cleared at each press.
REQ-035 Both keys pressed together, press aligned to tick cycle, and reset asserted mid-step -> both indices advance, no led step on that cycle; reset returns all outputs to REQ-026 values.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings, speed count and reset values for led_seq_ctrl
package led_pkg;

    typedef enum logic [1:0] {
        MODE_FLOW_L = 2'd0,
        MODE_FLOW_R = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam int         SPD_NUM     = 3;
    localparam mode_e      RST_MODE    = MODE_FLOW_L;
    localparam logic [1:0] RST_SPD     = 2'd1;
    localparam logic       RST_KEY_LVL = 1'b1;

    // The unused encoding 3 behaves exactly like speed 0.
    function automatic logic [1:0] spd_norm(input logic [1:0] s);
        return (s >= 2'(SPD_NUM)) ? 2'd0 : s;
    endfunction

    function automatic logic [1:0] spd_next(input logic [1:0] s);
        logic [1:0] n;
        n = spd_norm(s);
        return (n == 2'(SPD_NUM - 1)) ? 2'd0 : n + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer, stability debouncer and one-cycle press pulse
module key_debounce
    import led_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CNT + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CNT - 1)) begin
                deb_d   = sync2_q;
                press_d = deb_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_KEY_LVL;
            sync2_q <= RST_KEY_LVL;
            deb_q   <= RST_KEY_LVL;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED sequencer: debounced mode/speed keys, step tick generator, pattern FSM
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int LED_W     = 4,
    parameter int TICK_BASE = 12_500_000,
    parameter int DEB_CNT   = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_mode,
    input  logic             key_speed,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       spd
);

    localparam int TW  = $clog2(4 * TICK_BASE);
    localparam int TWP = TW + 1;
    localparam logic [LED_W-1:0] LED_ONEHOT_LO = LED_W'(1);
    localparam logic [LED_W-1:0] LED_ONEHOT_HI = LED_ONEHOT_LO << (LED_W - 1);
    localparam logic [LED_W-1:0] LED_ALL       = {LED_W{1'b1}};

    logic             mode_press, speed_press;
    mode_e            mode_q, mode_d, mode_nxt;
    logic [1:0]       spd_q, spd_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [TW:0]      period;
    logic [TW-1:0]    period_m1;
    logic             tick;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_mode),
        .press (mode_press)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_speed (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_speed),
        .press (speed_press)
    );

    // One extra bit so 4*TICK_BASE survives before the -1.
    always_comb begin
        period    = TWP'(TICK_BASE) << spd_norm(spd_q);
        period_m1 = TW'(period - TWP'(1));
        tick      = (mode_q != MODE_HOLD) && (tick_cnt_q == period_m1);
    end

    always_comb begin
        mode_d     = mode_q;
        mode_nxt   = mode_e'(mode_q + 2'd1);
        spd_d      = spd_q;
        led_d      = led_q;
        tick_cnt_d = tick_cnt_q + TW'(1);

        if (mode_q == MODE_HOLD || tick) begin
            tick_cnt_d = '0;
        end

        if (tick) begin
            case (mode_q)
                MODE_FLOW_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_FLOW_R: led_d = {led_q[0], led_q[LED_W-1:1]};
                MODE_BLINK:  led_d = ~led_q;
                default:     led_d = led_q;
            endcase
        end

        // Presses override any step that would land in the same cycle.
        if (speed_press) begin
            spd_d      = spd_next(spd_q);
            tick_cnt_d = '0;
            led_d      = led_q;
        end

        if (mode_press) begin
            mode_d     = mode_nxt;
            tick_cnt_d = '0;
            case (mode_nxt)
                MODE_FLOW_L: led_d = LED_ONEHOT_LO;
                MODE_FLOW_R: led_d = LED_ONEHOT_HI;
                MODE_BLINK:  led_d = LED_ALL;
                default:     led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q     <= RST_MODE;
            spd_q      <= RST_SPD;
            led_q      <= LED_ONEHOT_LO;
            tick_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            spd_q      <= spd_d;
            led_q      <= led_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign spd  = spd_q;

endmodule
